// File: rtl/cpri_rx_gen.sv
// cpri_rx_gen: splits the received 64-bit CPRI IQ word stream into
// CHUNK_LEN-word chunks and writes each accepted chunk into the RX loop
// buffer. wlast on the final word commits the chunk. Chunks that start
// while the buffer has no room are dropped and counted. Truncated chunks
// are never committed, and the next chunk overwrites them from address 0.
//
// Optional build macro: CPRI_RX_HDR_CHECK_EN
//   defined   - word 0 must carry HDR_MAGIC in bits [63:56]; otherwise the
//               chunk is dropped and counted in o_drop_cnt.
//   undefined - every header is accepted and no comparator is built.
module cpri_rx_gen #(
    parameter int            DATA_WIDTH = 64,
    parameter int            ADDR_WIDTH = 7,
    parameter int            CHUNK_LEN  = 96,
    parameter int            CNT_WIDTH  = 16,
    parameter logic [7:0]    HDR_MAGIC  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_iq_rx_valid,
    input  logic [DATA_WIDTH-1:0] i_iq_rx_data,
    input  logic                  i_wr_rdy,
    output logic                  o_cpri_wen,
    output logic [ADDR_WIDTH-1:0] o_cpri_waddr,
    output logic [DATA_WIDTH-1:0] o_cpri_wdata,
    output logic                  o_cpri_wlast,
    output logic [CNT_WIDTH-1:0]  o_chunk_cnt,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CHUNK_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   wcnt_q;
    logic                    wen_q;
    logic [ADDR_WIDTH-1:0]   waddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    wlast_q;
    logic                    err_q;
    logic [CNT_WIDTH-1:0]    chunk_cnt_q;
    logic [CNT_WIDTH-1:0]    drop_cnt_q;
    logic [CNT_WIDTH-1:0]    err_cnt_q;
    logic                    hdr_ok;

`ifdef CPRI_RX_HDR_CHECK_EN
    // Word-0 header qualifier: the top byte must carry the magic value.
    assign hdr_ok = (i_iq_rx_data[DATA_WIDTH-1 -: 8] == HDR_MAGIC);
`else
    // Header always accepted. The self-compare folds to a constant 1 and
    // keeps HDR_MAGIC referenced in this build.
    assign hdr_ok = (HDR_MAGIC == HDR_MAGIC);
`endif

    // Chunk FSM: word counting, registered write port, status counters.
    // NOTE: every register here is updated with <= so that all of them see
    // the values from the previous edge, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wlast_q     <= 1'b0;
            err_q       <= 1'b0;
            chunk_cnt_q <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            // Strobes are single-cycle and are low unless set below.
            wen_q   <= 1'b0;
            wlast_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_iq_rx_valid) begin
                        wcnt_q <= ADDR_WIDTH'(1);
                        if (i_wr_rdy && hdr_ok) begin
                            wen_q   <= 1'b1;
                            waddr_q <= '0;
                            wdata_q <= i_iq_rx_data;
                            state_q <= S_RECV;
                        end else begin
                            if (drop_cnt_q != CNT_MAX) drop_cnt_q <= drop_cnt_q + 1'b1;
                            state_q <= S_DROP;
                        end
                    end
                end
                S_RECV: begin
                    if (i_iq_rx_valid) begin
                        wen_q   <= 1'b1;
                        waddr_q <= wcnt_q;
                        wdata_q <= i_iq_rx_data;
                        if (wcnt_q == LAST_ADDR) begin
                            wlast_q     <= 1'b1;
                            chunk_cnt_q <= chunk_cnt_q + 1'b1;
                            wcnt_q      <= '0;
                            state_q     <= S_IDLE;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end else begin
                        // Truncated: nothing more is written and the partial
                        // chunk stays uncommitted.
                        err_q <= 1'b1;
                        if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + 1'b1;
                        wcnt_q  <= '0;
                        state_q <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (!i_iq_rx_valid || wcnt_q == LAST_ADDR) begin
                        wcnt_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                default: begin
                    wcnt_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cpri_wen   = wen_q;
    assign o_cpri_waddr = waddr_q;
    assign o_cpri_wdata = wdata_q;
    assign o_cpri_wlast = wlast_q;
    assign o_chunk_cnt  = chunk_cnt_q;
    assign o_drop_cnt   = drop_cnt_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_err        = err_q;

endmodule
